vec_multadd: RTL and testbench
==============================

Name: vec_multadd

Overview:
- Per-lane signed integer ALU for the vector datapath: add, subtract, multiply, pass-through, plus a fused multiply-accumulate mode for dot-product style reductions.
- Result and status flags are registered, with 1-cycle latency.
- One instance sits in each vector lane, between the register-file read ports and the writeback.

Parameters:
- vdw_p, 32, vector data width in bits (signed two's-complement operands and result); legal range 8..64.

Ports:
- clk_i  input  1  single clock; all state updates on rising edge.
- reset_n_i  input  1  reset, asynchronous and active-low (one clock; reset is asynchronous and active-low).
- a_i  input  vdw_p  signed operand A.
- b_i  input  vdw_p  signed operand B.
- alu_op_i  input  2  operation select: 0 ADD, 1 SUB, 2 MUL, 3 PASSA; ignored while use_fma_i=1.
- use_fma_i  input  1  1 = multiply-accumulate mode.
- fma_first_i  input  1  in FMA mode, first element of a reduction; clears the accumulator contribution.
- data_o  output  vdw_p  registered signed result.
- flag_overflow_o  output  1  registered signed overflow of the produced result.
- flag_zero_o  output  1  registered: data_o == 0.
- flag_negative_o  output  1  registered: data_o MSB.

Behaviour:
- Reset (reset_n_i=0, async): data_o=0, accumulator=0, all three flags=0. Reset is held while low; the first update happens on the first rising edge after release.
- Mid-operation reset: the accumulator is lost and the next FMA starts from 0 regardless of fma_first_i.
- Non-FMA (use_fma_i=0), result r registered each rising edge:
  - ADD: r = a_i + b_i.
  - SUB: r = a_i - b_i.
  - MUL: r = low vdw_p bits of a_i * b_i (full 2*vdw_p signed product computed internally).
  - PASSA: r = a_i.
- Non-FMA accumulator handling: the accumulator is loaded with r, so a following FMA without fma_first_i continues from the last result.
- FMA (use_fma_i=1): p = a_i * b_i truncated to vdw_p; acc_next = (fma_first_i ? 0 : acc) + p; acc and data_o both take acc_next. data_o always equals the accumulator.
- Latency: exactly 1 cycle from inputs sampled to data_o and flags. No handshake; a new operation is accepted every cycle.
- Overflow:
  - ADD/SUB: operand signs differ from the result sign per two's-complement rules.
  - MUL: full product not representable in vdw_p bits.
  - FMA: set if either the product or the accumulate step overflows.
  - PASSA: always 0.
- Overflow flag is sticky only for that cycle; it is not accumulated.
- Wrap-around: without SATURATE_EN, results wrap modulo 2^vdw_p.
- Zero and negative flags derive from the value actually written to data_o, including after saturation.

Optional Feature:
- Macro VEC_MULTADD_SATURATE_EN.
- Defined: on overflow, r clamps to +2^(vdw_p-1)-1 or -2^(vdw_p-1) according to the true result sign, and flag_overflow_o is still asserted. In FMA mode the clamped value is stored in the accumulator.
- Undefined: wrapping arithmetic as above.

Decomposition:
- Shared package vec_pkg:
  - enum alu_op_e {ALU_ADD=0, ALU_SUB=1, ALU_MUL=2, ALU_PASSA=3}.
  - Default data width constant VDW=32.
- One natural sub-module, vec_smul: combinational signed vdw_p x vdw_p multiplier returning the 2*vdw_p product and an overflow bit. It is reused by both MUL and FMA paths.

Test Plan:
- Reset low then release; a=1, b=3, op=ADD, wait 2 edges -> data_o=4, zero=0, neg=0, ovf=0.
- a=10, b=2, op=SUB -> data_o=8. Then a=2, b=10 -> data_o=-8, neg=1.
- a=7, b=3, op=MUL -> data_o=21. Then a=0, b=5 -> data_o=0, zero=1.
- Reset pulse, then use_fma=1, fma_first=1 for the first element only, a=1, b=1,2,3,4 on consecutive cycles -> data_o sequence 1, 3, 6, 10; restarting with fma_first=1 and b=5 -> 5.
- vdw_p=32: a=0x7FFFFFFF, b=1, ADD -> ovf=1, data_o=0x80000000 (wrap) or 0x7FFFFFFF with SATURATE_EN. MUL 0x10000 * 0x10000 -> ovf=1.
- Assert reset_n_i low asynchronously mid-FMA (between clock edges) -> data_o and flags go to 0 immediately; after release, FMA with fma_first=0, a=2, b=3 -> data_o=6.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared definitions for the vector lane ALU: operation encoding, default width
// and the two's-complement add overflow rule.
package vec_pkg;

  localparam int VDW = 32;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_MUL   = 2'd2,
    ALU_PASSA = 2'd3
  } alu_op_e;

  // Same-sign operands producing an opposite-sign sum means the sum wrapped.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/vec_smul.sv
// Combinational signed multiplier: full double-width product plus a flag that
// the product does not fit back into vdw_p bits.
module vec_smul #(
  parameter int vdw_p = 32
) (
  input  logic [vdw_p-1:0]   a_i,
  input  logic [vdw_p-1:0]   b_i,
  output logic [2*vdw_p-1:0] prod_o,
  output logic               ovf_o
);

  logic [2*vdw_p-1:0] a_ext;
  logic [2*vdw_p-1:0] b_ext;
  logic [vdw_p:0]     prod_hi;

  // Sign-extended operands make the low 2*vdw_p bits of an unsigned multiply
  // equal to the signed product.
  assign a_ext   = {{vdw_p{a_i[vdw_p-1]}}, a_i};
  assign b_ext   = {{vdw_p{b_i[vdw_p-1]}}, b_i};
  assign prod_o  = a_ext * b_ext;
  assign prod_hi = prod_o[2*vdw_p-1:vdw_p-1];
  assign ovf_o   = !((&prod_hi) || !(|prod_hi));

endmodule

// File: rtl/vec_multadd.sv
// Per-lane signed ALU with fused multiply-accumulate and registered flags.
// Define VEC_MULTADD_SATURATE_EN to clamp overflowing results instead of wrapping.
module vec_multadd
  import vec_pkg::*;
#(
  parameter int vdw_p = VDW
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [vdw_p-1:0] a_i,
  input  logic [vdw_p-1:0] b_i,
  input  logic [1:0]       alu_op_i,
  input  logic             use_fma_i,
  input  logic             fma_first_i,
  output logic [vdw_p-1:0] data_o,
  output logic             flag_overflow_o,
  output logic             flag_zero_o,
  output logic             flag_negative_o
);

  localparam int MSB = vdw_p - 1;

  logic [2*vdw_p-1:0] prod;
  logic               prod_ovf;

  logic [vdw_p-1:0] acc_q;
  logic             ovf_q, zero_q, neg_q;

  logic [vdw_p-1:0] sum_ab, dif_ab, base, fma_sum, r_wrap, r_d;
  logic             ovf_d, ovf_flag_d;

  vec_smul #(.vdw_p(vdw_p)) u_smul (
    .a_i    (a_i),
    .b_i    (b_i),
    .prod_o (prod),
    .ovf_o  (prod_ovf)
  );

  always_comb begin
    sum_ab  = a_i + b_i;
    dif_ab  = a_i - b_i;
    base    = fma_first_i ? '0 : acc_q;
    fma_sum = base + prod[vdw_p-1:0];
    r_wrap  = a_i;
    ovf_d   = 1'b0;
    if (use_fma_i) begin
      r_wrap = fma_sum;
      ovf_d  = prod_ovf | add_ovf(base[MSB], prod[MSB], fma_sum[MSB]);
    end else begin
      case (alu_op_e'(alu_op_i))
        ALU_ADD: begin
          r_wrap = sum_ab;
          ovf_d  = add_ovf(a_i[MSB], b_i[MSB], sum_ab[MSB]);
        end
        ALU_SUB: begin
          r_wrap = dif_ab;
          ovf_d  = add_ovf(a_i[MSB], ~b_i[MSB], dif_ab[MSB]);
        end
        ALU_MUL: begin
          r_wrap = prod[vdw_p-1:0];
          ovf_d  = prod_ovf;
        end
        default: begin
          r_wrap = a_i;
          ovf_d  = 1'b0;
        end
      endcase
    end
  end

`ifdef VEC_MULTADD_SATURATE_EN
  localparam logic [vdw_p-1:0] MaxPos = {1'b0, {(vdw_p-1){1'b1}}};
  localparam logic [vdw_p-1:0] MinNeg = {1'b1, {(vdw_p-1){1'b0}}};

  logic [2*vdw_p:0] fma_exact;
  logic             fma_oor, sat_need, sat_neg;

  // Exact accumulate against the untruncated product decides the clamp direction.
  assign fma_exact = {{(vdw_p+1){base[MSB]}}, base} + {prod[2*vdw_p-1], prod};
  assign fma_oor   = !((&fma_exact[2*vdw_p:MSB]) || !(|fma_exact[2*vdw_p:MSB]));

  always_comb begin
    sat_need   = ovf_d;
    sat_neg    = a_i[MSB];
    ovf_flag_d = ovf_d;
    if (use_fma_i) begin
      sat_need   = fma_oor;
      sat_neg    = fma_exact[2*vdw_p];
      ovf_flag_d = prod_ovf | fma_oor;
    end else if (alu_op_e'(alu_op_i) == ALU_MUL) begin
      sat_neg = prod[2*vdw_p-1];
    end
    r_d = sat_need ? (sat_neg ? MinNeg : MaxPos) : r_wrap;
  end
`else
  logic unused_prod_hi;

  assign unused_prod_hi = ^prod[2*vdw_p-1:vdw_p];
  assign r_d            = r_wrap;
  assign ovf_flag_d     = ovf_d;
`endif

  // The accumulator is the output register: every result reloads it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      acc_q  <= r_d;
      ovf_q  <= ovf_flag_d;
      zero_q <= (r_d == '0);
      neg_q  <= r_d[MSB];
    end
  end

  assign data_o          = acc_q;
  assign flag_overflow_o = ovf_q;
  assign flag_zero_o     = zero_q;
  assign flag_negative_o = neg_q;

endmodule

// File: tb/tb_vec_multadd.sv
// Scoreboard bench for vec_multadd (vdw_p=32): a longint reference model queues
// expected results at issue time and a monitor checks them one cycle later.
module tb_vec_multadd;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [1:0]  alu_op = '0;
  logic        use_fma = 1'b0;
  logic        fma_first = 1'b0;
  logic [31:0] data;
  logic        f_ovf, f_zero, f_neg;

  logic        issue_v = 1'b0;
  int          errors = 0;
  int          checks = 0;
  longint      acc_m = 0;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    logic        zero;
    logic        neg;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  vec_multadd #(.vdw_p(32)) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .a_i             (a),
    .b_i             (b),
    .alu_op_i        (alu_op),
    .use_fma_i       (use_fma),
    .fma_first_i     (fma_first),
    .data_o          (data),
    .flag_overflow_o (f_ovf),
    .flag_zero_o     (f_zero),
    .flag_negative_o (f_neg)
  );

  always #5 clk = ~clk;

  function automatic bit oor(longint t);
    return (t > 64'sd2147483647) || (t < -64'sd2147483648);
  endfunction

  function automatic longint wrapv(longint t);
    int w;
    w = int'(t);
    return longint'(w);
  endfunction

  function automatic longint clampv(longint t);
    if (t > 64'sd2147483647) return 64'sd2147483647;
    if (t < -64'sd2147483648) return -64'sd2147483648;
    return t;
  endfunction

  // Reference: exact integer arithmetic, then wrap or clamp to 32 bits.
  task automatic issue(string nm, logic [1:0] op, logic fma, logic first, int av, int bv);
    longint ta, tb, t, r, p_full, base;
    bit     ovf;
    exp_t   e;
    ta = av;
    tb = bv;
    if (fma) begin
      p_full = ta * tb;
      base   = first ? 0 : acc_m;
`ifdef VEC_MULTADD_SATURATE_EN
      t   = base + p_full;
      ovf = oor(p_full) || oor(t);
      r   = clampv(t);
`else
      t   = base + wrapv(p_full);
      ovf = oor(p_full) || oor(t);
      r   = wrapv(t);
`endif
    end else begin
      case (op)
        2'd0:    t = ta + tb;
        2'd1:    t = ta - tb;
        2'd2:    t = ta * tb;
        default: t = ta;
      endcase
      ovf = oor(t);
`ifdef VEC_MULTADD_SATURATE_EN
      r = clampv(t);
`else
      r = wrapv(t);
`endif
    end
    acc_m  = r;
    e.data = r[31:0];
    e.ovf  = ovf;
    e.zero = (r == 0);
    e.neg  = (r < 0);
    e.name = nm;
    @(negedge clk);
    a         = av;
    b         = bv;
    alu_op    = op;
    use_fma   = fma;
    fma_first = first;
    sb_q.push_back(e);
    issue_v   = 1'b1;
  endtask

  task automatic check_bit(string nm, logic got, logic exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, got, exp_v);
    end
  endtask

  task automatic check_reset_state(string nm);
    checks++;
    if (data !== 32'h0 || f_ovf !== 1'b0 || f_zero !== 1'b0 || f_neg !== 1'b0) begin
      errors++;
      $display("FAIL %s: got data=%h ovf=%b z=%b n=%b expected all zero",
               nm, data, f_ovf, f_zero, f_neg);
    end
  endtask

  // Async reset asserted mid-cycle, held over one rising edge, released before
  // the next issue so no unmodelled operation reaches the accumulator.
  task automatic do_reset(string nm);
    @(negedge clk);
    issue_v = 1'b0;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_state(nm);
    acc_m = 0;
    #8;
    reset_n = 1'b1;
  endtask

  function automatic int rand_operand();
    int sel;
    int v;
    sel = int'($urandom_range(0, 3));
    case (sel)
      0: v = int'($urandom_range(0, 40)) - 20;
      1: v = int'($urandom);
      2: begin
        case ($urandom_range(0, 4))
          0: v = 32'h7FFFFFFF;
          1: v = 32'h80000000;
          2: v = -1;
          3: v = 0;
          default: v = 1;
        endcase
      end
      default: v = int'($urandom_range(0, 131071)) - 65536;
    endcase
    return v;
  endfunction

  // Monitor: one registered result per issued cycle.
  initial begin
    bit   v;
    exp_t e;
    forever begin
      @(posedge clk);
      v = issue_v;
      #1;
      if (v) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_underflow: got output data=%h with no expected entry", data);
        end else begin
          e = sb_q.pop_front();
          if (data !== e.data || f_ovf !== e.ovf || f_zero !== e.zero || f_neg !== e.neg) begin
            errors++;
            $display("FAIL %s: got data=%h ovf=%b z=%b n=%b expected data=%h ovf=%b z=%b n=%b",
                     e.name, data, f_ovf, f_zero, f_neg, e.data, e.ovf, e.zero, e.neg);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    #2;
    check_reset_state("reset_initial");
    #10;
    reset_n = 1'b1;

    issue("add_1_3", 2'd0, 1'b0, 1'b0, 1, 3);
    issue("sub_10_2", 2'd1, 1'b0, 1'b0, 10, 2);
    issue("sub_2_10", 2'd1, 1'b0, 1'b0, 2, 10);
    issue("mul_7_3", 2'd2, 1'b0, 1'b0, 7, 3);
    issue("mul_0_5", 2'd2, 1'b0, 1'b0, 0, 5);
    issue("passa", 2'd3, 1'b0, 1'b0, -42, 99);

    do_reset("reset_pulse");
    issue("fma_b1", 2'd0, 1'b1, 1'b1, 1, 1);
    issue("fma_b2", 2'd0, 1'b1, 1'b0, 1, 2);
    issue("fma_b3", 2'd0, 1'b1, 1'b0, 1, 3);
    issue("fma_b4", 2'd0, 1'b1, 1'b0, 1, 4);
    issue("fma_restart", 2'd0, 1'b1, 1'b1, 1, 5);
    issue("mul_then_fma", 2'd2, 1'b0, 1'b0, 6, 7);
    issue("fma_continue", 2'd1, 1'b1, 1'b0, 2, 4);

    issue("add_ovf_max", 2'd0, 1'b0, 1'b0, 32'h7FFFFFFF, 1);
    issue("sub_ovf_min", 2'd1, 1'b0, 1'b0, 32'h80000000, 1);
    issue("mul_ovf_2p32", 2'd2, 1'b0, 1'b0, 32'h00010000, 32'h00010000);
    issue("mul_min_neg1", 2'd2, 1'b0, 1'b0, 32'h80000000, -1);
    issue("passa_min", 2'd3, 1'b0, 1'b0, 32'h80000000, 32'h7FFFFFFF);
    issue("fma_acc_ovf0", 2'd0, 1'b1, 1'b1, 32'h40000000, 1);
    issue("fma_acc_ovf1", 2'd0, 1'b1, 1'b0, 32'h40000000, 1);
    issue("fma_prod_ovf", 2'd0, 1'b1, 1'b1, 32'h00020000, 32'h00020000);

    issue("fma_pre_rst0", 2'd0, 1'b1, 1'b1, 5, 5);
    issue("fma_pre_rst1", 2'd0, 1'b1, 1'b0, 5, 5);
    do_reset("reset_mid_fma");
    check_bit("reset_mid_fma_ovf", f_ovf, 1'b0);
    issue("fma_after_rst", 2'd0, 1'b1, 1'b0, 2, 3);

    for (int i = 0; i < 300; i++) begin
      logic [1:0] op;
      logic       fma, first;
      op    = 2'($urandom_range(0, 3));
      fma   = ($urandom_range(0, 2) == 0);
      first = ($urandom_range(0, 3) == 0);
      issue("random", op, fma, first, rand_operand(), rand_operand());
    end

    @(negedge clk);
    issue_v = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
